// File: rtl/logic_frame_pkg.sv
// Shared constants for the logic-analyser capture framer/parser pair:
// channel IDs, trailer geometry, error codes and the parser FSM states.
package logic_frame_pkg;

  localparam logic [1:0] CH_IIC  = 2'd0;
  localparam logic [1:0] CH_SPI  = 2'd1;
  localparam logic [1:0] CH_UART = 2'd2;

  localparam int TRL_LEN = 48;
  localparam int SEC_LEN = 16;
  localparam int PAY_MAX = 15;

  localparam logic [1:0] ERR_SHORT = 2'd1;
  localparam logic [1:0] ERR_LONG  = 2'd2;
  localparam logic [1:0] ERR_OVF   = 2'd3;

  typedef enum logic [1:0] {
    S_SAMPLE = 2'd0,
    S_CNT    = 2'd1,
    S_PAY    = 2'd2,
    S_RESYNC = 2'd3
  } state_t;

endpackage

// File: rtl/logic_frame_parser.sv
// Splits a framer byte stream into sample bytes and channel-tagged protocol
// bytes (three count+payload trailer sections), flagging malformed frames.
module logic_frame_parser
  import logic_frame_pkg::*;
#(
  parameter int P_SEND_LEN = 1000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_data,
  input  logic        i_vld,
  input  logic        i_last,
  output logic [7:0]  o_sam_data,
  output logic        o_sam_vld,
  output logic        o_sam_last,
  output logic [7:0]  o_proto_data,
  output logic        o_proto_vld,
  output logic [1:0]  o_proto_ch,
  output logic        o_proto_last,
  output logic        o_frame_done,
  output logic        o_frame_err,
  output logic [1:0]  o_err_code,
  output logic [15:0] o_frame_cnt
);

  localparam int SAM_W = $clog2(P_SEND_LEN + 1);
  localparam logic [SAM_W-1:0] SAM_LAST  = SAM_W'(P_SEND_LEN - 1);
  localparam logic [5:0]       TRL_LAST  = 6'(TRL_LEN - 1);
  localparam logic [3:0]       PAY_LAST  = 4'(PAY_MAX - 1);
  localparam logic [3:0]       PAY_CLAMP = 4'(PAY_MAX);

  state_t           r_state;
  logic [SAM_W-1:0] r_sam_cnt;
  logic [1:0]       r_sec;
  logic [3:0]       r_pay_idx;
  logic [3:0]       r_pay_len;
  logic [5:0]       r_trl_idx;

  logic [7:0]  r_sam_data;
  logic        r_sam_vld;
  logic        r_sam_last;
  logic [7:0]  r_proto_data;
  logic        r_proto_vld;
  logic [1:0]  r_proto_ch;
  logic        r_proto_last;
  logic        r_frame_done;
  logic        r_frame_err;
  logic [1:0]  r_err_code;
  logic [15:0] r_frame_cnt;

  logic w_pay_emit;
  logic w_pay_last;
  logic w_trl_end;
  logic w_cnt_ovf;
  logic w_sam_end;

  assign w_pay_emit = (r_pay_idx < r_pay_len);
  // pay_len=0 can never match here since pay_idx never reaches 15.
  assign w_pay_last = w_pay_emit && ((r_pay_idx + 4'd1) == r_pay_len);
  assign w_trl_end  = (r_trl_idx == TRL_LAST);
  assign w_cnt_ovf  = (i_data > 8'(PAY_MAX));
  assign w_sam_end  = (r_sam_cnt == SAM_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= S_SAMPLE;
      r_sam_cnt    <= '0;
      r_sec        <= '0;
      r_pay_idx    <= '0;
      r_pay_len    <= '0;
      r_trl_idx    <= '0;
      r_sam_data   <= '0;
      r_sam_vld    <= 1'b0;
      r_sam_last   <= 1'b0;
      r_proto_data <= '0;
      r_proto_vld  <= 1'b0;
      r_proto_ch   <= '0;
      r_proto_last <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_err_code   <= '0;
      r_frame_cnt  <= '0;
    end else begin
      r_sam_vld    <= 1'b0;
      r_sam_last   <= 1'b0;
      r_proto_vld  <= 1'b0;
      r_proto_last <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      if (i_vld) begin
        case (r_state)
          S_SAMPLE: begin
            r_sam_data <= i_data;
            r_sam_vld  <= 1'b1;
            r_sam_last <= w_sam_end;
            if (i_last) begin
              r_frame_err <= 1'b1;
              r_err_code  <= ERR_SHORT;
              r_sam_cnt   <= '0;
            end else if (w_sam_end) begin
              r_sam_cnt <= '0;
              r_sec     <= CH_IIC;
              r_trl_idx <= '0;
              r_state   <= S_CNT;
            end else begin
              r_sam_cnt <= r_sam_cnt + SAM_W'(1);
            end
          end

          S_CNT: begin
            r_trl_idx <= r_trl_idx + 6'd1;
            // A truncated frame outranks an oversized count on the same byte.
            if (i_last) begin
              r_frame_err <= 1'b1;
              r_err_code  <= ERR_SHORT;
              r_state     <= S_SAMPLE;
            end else begin
              r_pay_len <= w_cnt_ovf ? PAY_CLAMP : i_data[3:0];
              r_pay_idx <= '0;
              r_state   <= S_PAY;
              if (w_cnt_ovf) begin
                r_frame_err <= 1'b1;
                r_err_code  <= ERR_OVF;
              end
            end
          end

          S_PAY: begin
            r_trl_idx <= r_trl_idx + 6'd1;
            r_pay_idx <= r_pay_idx + 4'd1;
            if (w_pay_emit) begin
              r_proto_data <= i_data;
              r_proto_ch   <= r_sec;
              r_proto_vld  <= 1'b1;
              r_proto_last <= w_pay_last;
            end
            if (i_last) begin
              r_state <= S_SAMPLE;
              if (w_trl_end) begin
                r_frame_done <= 1'b1;
                r_frame_cnt  <= r_frame_cnt + 16'd1;
              end else begin
                r_frame_err <= 1'b1;
                r_err_code  <= ERR_SHORT;
              end
            end else if (r_pay_idx == PAY_LAST) begin
              if (r_sec != CH_UART) begin
                r_sec   <= r_sec + 2'd1;
                r_state <= S_CNT;
              end else begin
                r_frame_err <= 1'b1;
                r_err_code  <= ERR_LONG;
                r_state     <= S_RESYNC;
              end
            end
          end

          S_RESYNC: begin
            if (i_last) begin
              r_state <= S_SAMPLE;
            end
          end

          default: r_state <= S_SAMPLE;
        endcase
      end
    end
  end

  assign o_sam_data   = r_sam_data;
  assign o_sam_vld    = r_sam_vld;
  assign o_sam_last   = r_sam_last;
  assign o_proto_data = r_proto_data;
  assign o_proto_vld  = r_proto_vld;
  assign o_proto_ch   = r_proto_ch;
  assign o_proto_last = r_proto_last;
  assign o_frame_done = r_frame_done;
  assign o_frame_err  = r_frame_err;
  assign o_err_code   = r_err_code;
  assign o_frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_logic_frame_parser.sv
// Directed, table-driven bench for logic_frame_parser with an 8-byte sample block:
// each record is one input cycle plus the outputs expected one cycle later.
module tb_logic_frame_parser;
  import logic_frame_pkg::*;

  typedef struct {
    bit         rst_n;
    bit         vld;
    bit         lst;
    logic [7:0] d;
    bit         sv;
    bit         sl;
    logic [7:0] sd;
    bit         pv;
    bit         pl;
    logic [7:0] pd;
    logic [1:0] pc;
    bit         dn;
    bit         er;
    logic [1:0] code;
    logic [15:0] cnt;
    bit         zero;
    int         scen;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [7:0]  data;
  logic        vld;
  logic        last;
  logic [7:0]  sam_data;
  logic        sam_vld;
  logic        sam_last;
  logic [7:0]  proto_data;
  logic        proto_vld;
  logic [1:0]  proto_ch;
  logic        proto_last;
  logic        frame_done;
  logic        frame_err;
  logic [1:0]  err_code;
  logic [15:0] frame_cnt;

  vec_t        vecs[$];
  logic [1:0]  exp_code;
  logic [15:0] exp_cnt;
  bit          gap_mode;
  bit          sim_done;
  int          cur_vec;
  int          scen;
  int          n_tests;
  int          n_fail;

  logic_frame_parser #(.P_SEND_LEN(8)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_data       (data),
    .i_vld        (vld),
    .i_last       (last),
    .o_sam_data   (sam_data),
    .o_sam_vld    (sam_vld),
    .o_sam_last   (sam_last),
    .o_proto_data (proto_data),
    .o_proto_vld  (proto_vld),
    .o_proto_ch   (proto_ch),
    .o_proto_last (proto_last),
    .o_frame_done (frame_done),
    .o_frame_err  (frame_err),
    .o_err_code   (err_code),
    .o_frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    sim_done = 1'b0;
    cur_vec  = 0;
    #2000000;
    if (!sim_done) begin
      $display("FAIL timeout: wait expired at vec%0d before all vectors were applied", cur_vec);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $finish;
    end
  end

  task automatic push(input bit r, input bit v, input bit l, input logic [7:0] d,
                      input bit sv, input bit sl, input logic [7:0] sd,
                      input bit pv, input bit pl, input logic [7:0] pd, input logic [1:0] pc,
                      input bit dn, input bit er);
    vec_t x;
    vec_t w;
    x.rst_n = r;   x.vld = v;   x.lst = l;   x.d = d;
    x.sv = sv;     x.sl = sl;   x.sd = sd;
    x.pv = pv;     x.pl = pl;   x.pd = pd;   x.pc = pc;
    x.dn = dn;     x.er = er;
    x.code = exp_code; x.cnt = exp_cnt;
    x.zero = !r;   x.scen = scen;
    vecs.push_back(x);
    if (gap_mode && v) begin
      w = x;
      w.vld = 1'b0; w.lst = 1'b1; w.d = 8'hEE;
      w.sv = 1'b0; w.sl = 1'b0; w.pv = 1'b0; w.pl = 1'b0;
      w.dn = 1'b0; w.er = 1'b0; w.zero = 1'b0;
      vecs.push_back(w);
      vecs.push_back(w);
    end
  endtask

  task automatic sam_bytes();
    for (int i = 0; i < 8; i++)
      push(1, 1, 0, 8'(i), 1, (i == 7), 8'(i), 0, 0, 8'h00, 2'd0, 0, 0);
  endtask

  task automatic cnt_byte(input logic [7:0] d, input bit er);
    push(1, 1, 0, d, 0, 0, 8'h00, 0, 0, 8'h00, 2'd0, 0, er);
  endtask

  task automatic pay_sec(input logic [1:0] ch, input int n, input logic [7:0] base, input bit fin);
    for (int i = 0; i < 15; i++) begin
      bit         emit;
      bit         l;
      logic [7:0] d;
      emit = (i < n);
      d    = emit ? base + 8'(i) : 8'hFF;
      l    = fin && (i == 14);
      if (l) exp_cnt = exp_cnt + 16'd1;
      push(1, 1, l, d, 0, 0, 8'h00, emit, emit && (i == n - 1), d, ch, l, 0);
    end
  endtask

  task automatic good_frame(input int c0, input logic [7:0] b0, input int c1,
                            input logic [7:0] b1, input int c2, input logic [7:0] b2);
    sam_bytes();
    cnt_byte(8'(c0), 0); pay_sec(CH_IIC,  c0, b0, 0);
    cnt_byte(8'(c1), 0); pay_sec(CH_SPI,  c1, b1, 0);
    cnt_byte(8'(c2), 0); pay_sec(CH_UART, c2, b2, 1);
  endtask

  initial begin
    rst_n = 1'b0; vld = 1'b0; last = 1'b0; data = 8'h00;
    exp_code = 2'd0; exp_cnt = 16'd0; gap_mode = 1'b0;
    n_tests = 0; n_fail = 0;

    scen = 1;
    push(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 2'd0, 0, 0);
    push(0, 1, 1, 8'h5A, 0, 0, 8'h00, 0, 0, 8'h00, 2'd0, 0, 0);
    scen = 2;
    good_frame(2, 8'hA1, 0, 8'h00, 15, 8'h30);
    scen = 3;
    gap_mode = 1'b1;
    good_frame(2, 8'hA1, 0, 8'h00, 15, 8'h30);
    gap_mode = 1'b0;
    scen = 4;
    sam_bytes();
    cnt_byte(8'd2, 0); pay_sec(CH_IIC, 2, 8'hA1, 0);
    cnt_byte(8'd0, 0);
    for (int i = 0; i < 3; i++) push(1, 1, 0, 8'hFF, 0, 0, 8'h00, 0, 0, 8'h00, 2'd0, 0, 0);
    exp_code = ERR_SHORT;
    push(1, 1, 1, 8'hFF, 0, 0, 8'h00, 0, 0, 8'h00, 2'd0, 0, 1);
    good_frame(1, 8'h11, 1, 8'h22, 1, 8'h33);
    scen = 5;
    sam_bytes();
    cnt_byte(8'd0, 0); pay_sec(CH_IIC, 0, 8'h00, 0);
    cnt_byte(8'd0, 0); pay_sec(CH_SPI, 0, 8'h00, 0);
    cnt_byte(8'd0, 0);
    for (int i = 0; i < 14; i++) push(1, 1, 0, 8'hFF, 0, 0, 8'h00, 0, 0, 8'h00, 2'd0, 0, 0);
    exp_code = ERR_LONG;
    push(1, 1, 0, 8'hFF, 0, 0, 8'h00, 0, 0, 8'h00, 2'd0, 0, 1);
    for (int i = 0; i < 5; i++)
      push(1, 1, (i == 4), 8'h90 + 8'(i), 0, 0, 8'h00, 0, 0, 8'h00, 2'd0, 0, 0);
    good_frame(1, 8'h11, 0, 8'h00, 0, 8'h00);
    scen = 6;
    sam_bytes();
    exp_code = ERR_OVF;
    cnt_byte(8'h20, 1); pay_sec(CH_IIC, 15, 8'h40, 0);
    cnt_byte(8'd1, 0);  pay_sec(CH_SPI, 1, 8'h60, 0);
    cnt_byte(8'd2, 0);  pay_sec(CH_UART, 2, 8'h70, 1);
    scen = 7;
    sam_bytes();
    exp_code = ERR_SHORT;
    push(1, 1, 1, 8'h20, 0, 0, 8'h00, 0, 0, 8'h00, 2'd0, 0, 1);
    good_frame(0, 8'h00, 3, 8'hB0, 0, 8'h00);
    scen = 8;
    sam_bytes();
    cnt_byte(8'd2, 0); pay_sec(CH_IIC, 2, 8'hA1, 0);
    cnt_byte(8'd3, 0);
    push(1, 1, 0, 8'h50, 0, 0, 8'h00, 1, 0, 8'h50, CH_SPI, 0, 0);
    exp_code = 2'd0; exp_cnt = 16'd0;
    push(0, 1, 0, 8'h51, 0, 0, 8'h00, 0, 0, 8'h00, 2'd0, 0, 0);
    good_frame(2, 8'hA1, 0, 8'h00, 15, 8'h30);

    @(negedge clk);
    rst_n = 1'b0; vld = 1'b1; last = 1'b1; data = 8'hA5;
    @(posedge clk);
    #1;
    n_tests++;
    if ((sam_data !== 8'h00) || (sam_vld !== 1'b0) || (sam_last !== 1'b0) ||
        (proto_data !== 8'h00) || (proto_vld !== 1'b0) || (proto_ch !== 2'd0) ||
        (proto_last !== 1'b0) || (frame_done !== 1'b0) || (frame_err !== 1'b0) ||
        (err_code !== 2'd0) || (frame_cnt !== 16'd0)) begin
      n_fail++;
      $display("FAIL reset-state: sd=%h sv=%b sl=%b pd=%h pv=%b pc=%0d pl=%b done=%b err=%b code=%0d cnt=%0d, need all 0",
               sam_data, sam_vld, sam_last, proto_data, proto_vld, proto_ch, proto_last,
               frame_done, frame_err, err_code, frame_cnt);
    end else begin
      $display("reset-state in: rst_n=0 vld=1 last=1 d=a5 ok (all outputs 0)");
    end

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      bit   bad;
      v = vecs[i];
      cur_vec = i;
      @(negedge clk);
      rst_n = v.rst_n; vld = v.vld; last = v.lst; data = v.d;
      @(posedge clk);
      #1;
      bad = (sam_vld !== v.sv) || (sam_last !== v.sl) || (proto_vld !== v.pv) ||
            (proto_last !== v.pl) || (frame_done !== v.dn) || (frame_err !== v.er) ||
            (err_code !== v.code) || (frame_cnt !== v.cnt);
      if ((v.sv || v.zero) && (sam_data !== v.sd)) bad = 1'b1;
      if ((v.pv || v.zero) && ((proto_data !== v.pd) || (proto_ch !== v.pc))) bad = 1'b1;
      n_tests++;
      if (bad) begin
        n_fail++;
        $display("FAIL vec%0d scen%0d: got sv=%b sd=%h sl=%b pv=%b pd=%h pc=%0d pl=%b done=%b err=%b code=%0d cnt=%0d, need sv=%b sd=%h sl=%b pv=%b pd=%h pc=%0d pl=%b done=%b err=%b code=%0d cnt=%0d",
                 i, v.scen, sam_vld, sam_data, sam_last, proto_vld, proto_data, proto_ch,
                 proto_last, frame_done, frame_err, err_code, frame_cnt,
                 v.sv, v.sd, v.sl, v.pv, v.pd, v.pc, v.pl, v.dn, v.er, v.code, v.cnt);
      end else begin
        $display("vec%0d scen%0d in: rst_n=%b vld=%b last=%b d=%h ok (sv=%b pv=%b done=%b err=%b code=%0d cnt=%0d)",
                 i, v.scen, v.rst_n, v.vld, v.lst, v.d, sam_vld, proto_vld, frame_done,
                 frame_err, err_code, frame_cnt);
      end
    end

    sim_done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_frame_parser.md
# logic_frame_parser

Receive-side counterpart of the logic-analyser capture framer. Consumes the byte stream the framer emits (P_SEND_LEN sample bytes, then a 48-byte protocol trailer, `last` on the final trailer byte). Splits it into a sample-byte stream and a channel-tagged stream of decoded IIC/SPI/UART bytes, and flags malformed frames. It sits in the loopback self-test path and in the host-side bridge ahead of the Ethernet packer.

## Interface
- P_SEND_LEN, 1000, sample bytes per frame; must match the framer.
- i_clk  in  1  capture-domain clock.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_data  in  8  frame byte.
- i_vld  in  1  byte strobe; gaps allowed; there is no backpressure.
- i_last  in  1  end-of-frame, qualified by i_vld.
- o_sam_data  out  8  sample byte.
- o_sam_vld  out  1  sample byte strobe.
- o_sam_last  out  1  on sample byte P_SEND_LEN.
- o_proto_data  out  8  decoded protocol byte.
- o_proto_vld  out  1  protocol byte strobe.
- o_proto_ch  out  2  0=IIC, 1=SPI, 2=UART.
- o_proto_last  out  1  last valid byte of the current channel.
- o_frame_done  out  1  one-cycle pulse: well-formed frame completed.
- o_frame_err  out  1  one-cycle pulse: frame error.
- o_err_code  out  2  1=short, 2=long, 3=count overflow; holds until the next error.
- o_frame_cnt  out  16  good-frame counter, wraps at 0xFFFF to 0.

## Operation
- Only bytes with i_vld=1 are processed. Cycles with i_vld=0 change no state.
- FSM states: S_SAMPLE, S_CNT, S_PAY, S_RESYNC.
- Counters:
  - sam_cnt: $clog2(P_SEND_LEN+1) bits.
  - sec: 0..2.
  - pay_idx: 0..14, 4 bits.
  - pay_len: 0..15, 4 bits.
  - trl_idx: 0..47, 6 bits.
- S_SAMPLE:
  - Forward each byte to o_sam_*.
  - At byte P_SEND_LEN, assert o_sam_last and go to S_CNT with sec=0, trl_idx=0.
- S_CNT:
  - Latch pay_len = min(byte,15).
  - byte>15: pulse o_frame_err, o_err_code=3, then continue parsing with the clamped value.
  - Go to S_PAY with pay_idx=0.
- S_PAY:
  - Consume exactly 15 bytes.
  - Emit the byte on o_proto_* with o_proto_ch=sec only when pay_idx<pay_len. Drop the rest as padding.
  - o_proto_last accompanies pay_idx==pay_len-1. pay_len=0 emits nothing.
  - After pay_idx=14: if sec<2, go to S_CNT with sec+1; otherwise the frame ends.
- trl_idx increments on every trailer byte.
- Frame end:
  - i_last expected with trl_idx==47.
  - Match: pulse o_frame_done, increment o_frame_cnt, go to S_SAMPLE.
  - i_last earlier (in any state, including S_SAMPLE): short error (code 1). The frame ends and the FSM goes to S_SAMPLE. Bytes already forwarded stand.
  - No i_last at trl_idx==47: long error (code 2). Go to S_RESYNC, discarding bytes until i_last, then S_SAMPLE.
- Same-byte priority: i_last-short > overflow. At most one o_frame_err pulse per byte.
- o_frame_done and o_frame_err are never asserted together.

## Timing
- All outputs registered. Latency from input byte to o_sam_*/o_proto_* is 1 cycle.
- o_frame_done / o_frame_err rise 1 cycle after the byte that causes them.
- Back-to-back frames are supported: the byte after i_last is parsed as sample byte 1, with no idle cycle required.
- Reset (also mid-frame), on the first i_clk edge with i_rst_n=0:
  - FSM goes to S_SAMPLE and all counters clear.
  - All outputs go to 0: data, strobes, o_err_code, o_frame_cnt.
  - The remainder of the interrupted frame is parsed as a new frame and will flag an error.
- Strobe outputs are 0 on every cycle without a qualifying input byte.

## Structure
- Package logic_frame_pkg, holding:
  - channel IDs: CH_IIC, CH_SPI, CH_UART;
  - trailer constants: TRL_LEN=48, SEC_LEN=16, PAY_MAX=15;
  - error codes: ERR_SHORT, ERR_LONG, ERR_OVF;
  - the FSM state enum.
- Shared with the framer and the test bench.
- Flat implementation with no sub-module; the datapath is counters plus one FSM.

## Test plan
All scenarios use P_SEND_LEN=8.
- Good frame, samples 0x00..0x07, counts IIC=2 [A1 A2], SPI=0, UART=15 [0x30..0x3E], padding 0xFF:
  - o_sam_last on 0x07.
  - Protocol output: ch0 A1, A2 (last on A2), then ch2 0x30..0x3E (last on 0x3E).
  - No padding emitted; one o_frame_done; o_frame_cnt=1.
- Valid gaps: same frame with i_vld toggling 1-0-0-1 → identical output sequence, with every output 1 cycle after its accepted byte.
- Short frame: i_last on trailer byte 20 → o_frame_err, o_err_code=1. The next good frame is parsed correctly and o_frame_cnt increments.
- Long frame: no i_last at byte 47, i_last 5 bytes later → o_err_code=2, no output during S_RESYNC, then a good frame is accepted.
- Count overflow: IIC count 0x20 → o_err_code=3, 15 ch0 bytes emitted, then SPI/UART sections parsed normally and o_frame_done issued.
- Reset: i_rst_n low for 1 cycle mid-SPI section → all outputs 0 on the next cycle. A fresh good frame then yields o_frame_cnt=1.
